// File: rtl/sd_byte_feeder.sv
// Byte FIFO feeding the SD block writer over the fo_start/fo_finish handshake.
// Closes a partial block on request by injecting END_TOKEN once the FIFO drains.
module sd_byte_feeder #(
    parameter int         DEPTH_LOG2  = 4,
    parameter logic [7:0] END_TOKEN   = 8'h2D,
    parameter int         BLOCK_BYTES = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    input  logic                  sd_ready,
    output logic [7:0]            fo_data,
    output logic                  fo_start,
    input  logic                  fo_finish,
    output logic                  busy,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic [15:0]           block_count
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CNT_W = $clog2(BLOCK_BYTES);

    typedef enum logic [1:0] {IDLE, REQ, ACK, REL} state_t;
    state_t state, stateNext;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr, rdPtr;
    logic [DEPTH_LOG2:0]   count;
    logic                  push, pop, loadToken, clearFlush;
    logic                  flushPending, fifoEmpty, overflowReg;
    logic [CNT_W-1:0]      byteCnt;
    logic [7:0]            foData;
    logic [15:0]           blockCnt;

    assign fifoEmpty = (count == '0);
    assign in_ready  = (count != (DEPTH_LOG2 + 1)'(DEPTH));
    assign push      = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A strobe arriving while a flush is pending (or being serviced) is absorbed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flushPending <= 1'b0;
            overflowReg  <= 1'b0;
        end else begin
            if (clearFlush) begin
                flushPending <= 1'b0;
            end else if (flush) begin
                flushPending <= 1'b1;
            end
            if (in_valid && !in_ready) begin
                overflowReg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        pop        = 1'b0;
        loadToken  = 1'b0;
        clearFlush = 1'b0;
        case (state)
            IDLE: begin
                if (sd_ready && fo_finish) begin
                    if (!fifoEmpty) begin
                        pop       = 1'b1;
                        stateNext = REQ;
                    end else if (flushPending) begin
                        clearFlush = 1'b1;
                        // Nothing written since the last close: no empty block.
                        if (byteCnt != '0) begin
                            loadToken = 1'b1;
                            stateNext = REQ;
                        end
                    end
                end
            end
            REQ:     if (!fo_finish) stateNext = ACK;
            ACK:     if (fo_finish)  stateNext = REL;
            REL:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            foData   <= '0;
            byteCnt  <= '0;
            blockCnt <= '0;
        end else begin
            if (pop) begin
                foData <= mem[rdPtr];
            end else if (loadToken) begin
                foData <= END_TOKEN;
            end
            // Accounted when the writer latches the byte.
            if (state == REQ && !fo_finish) begin
                if (foData == END_TOKEN || byteCnt == CNT_W'(BLOCK_BYTES - 1)) begin
                    byteCnt  <= '0;
                    blockCnt <= blockCnt + 1'b1;
                end else begin
                    byteCnt <= byteCnt + 1'b1;
                end
            end
        end
    end

    assign fo_data     = foData;
    assign fo_start    = (state == REQ) || (state == ACK);
    assign busy        = !fifoEmpty || flushPending || (state != IDLE);
    assign overflow    = overflowReg;
    assign fifo_count  = count;
    assign block_count = blockCnt;

endmodule

// File: tb/tb_sd_byte_feeder.sv
// Self-checking bench for sd_byte_feeder: directed vectors plus a simple SD writer model.
module tb_sd_byte_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        sd_ready = 1'b0;
    logic [7:0]  fo_data;
    logic        fo_start;
    logic        fo_finish;
    logic        busy;
    logic        overflow;
    logic [4:0]  fifo_count;
    logic [15:0] block_count;

    logic        writerEn = 1'b0;
    logic        manualFinish = 1'b1;
    logic        modelFinish = 1'b1;
    int          wDelay = 0;
    bit          wArmed = 1'b1;
    logic [7:0]  gotQ[$];

    int passCount = 0;
    int totalCount = 0;

    assign fo_finish = writerEn ? modelFinish : manualFinish;

    always #5 clk = ~clk;

    sd_byte_feeder dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .sd_ready    (sd_ready),
        .fo_data     (fo_data),
        .fo_start    (fo_start),
        .fo_finish   (fo_finish),
        .busy        (busy),
        .overflow    (overflow),
        .fifo_count  (fifo_count),
        .block_count (block_count)
    );

    // Writer: latches a byte two clocks after seeing fo_start, then needs fo_start low again.
    always @(negedge clk) begin
        if (!writerEn) begin
            wDelay = 0;
            wArmed = 1'b1;
            modelFinish = 1'b1;
        end else if (modelFinish) begin
            if (fo_start && wArmed) begin
                wDelay++;
                if (wDelay >= 2) begin
                    gotQ.push_back(fo_data);
                    modelFinish = 1'b0;
                    wDelay = 0;
                end
            end else if (!fo_start) begin
                wArmed = 1'b1;
            end
        end else begin
            modelFinish = 1'b1;
            wArmed = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic waitIdle(input int maxC, input string name);
        bit done = 1'b0;
        for (int i = 0; i < maxC; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        check({name, "_idle"}, 32'(done), 32'd1);
    endtask

    task automatic pulseFlush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic feed(input int n, input logic [7:0] val);
        int sent = 0;
        for (int c = 0; c < n * 20 && sent < n; c++) begin
            @(negedge clk);
            if (in_ready) begin
                in_valid = 1'b1;
                in_data  = val;
                sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("feed_sent", 32'(sent), 32'(n));
    endtask

    typedef struct {
        logic       valid;
        logic [7:0] data;
        int         expCount;
        logic       expReady;
        logic       expOvf;
    } pushVec_t;

    pushVec_t vecs[17];

    initial begin
        int base;

        for (int i = 0; i < 17; i++) begin
            vecs[i].valid    = 1'b1;
            vecs[i].data     = 8'h60 + 8'(i);
            vecs[i].expCount = (i + 1 < 16) ? i + 1 : 16;
            vecs[i].expReady = (i + 1 < 16);
            vecs[i].expOvf   = (i == 16);
        end

        // T1: reset held with in_valid asserted
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (3) @(negedge clk);
        check("t1_fifo_count", 32'(fifo_count), 32'd0);
        check("t1_fo_start", 32'(fo_start), 32'd0);
        check("t1_in_ready", 32'(in_ready), 32'd1);
        check("t1_overflow", 32'(overflow), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_block_count", 32'(block_count), 32'd0);
        in_valid = 1'b0;
        reset    = 1'b1;

        // T2: three bytes through the writer
        writerEn = 1'b1;
        sd_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h41;
        @(negedge clk);
        in_data  = 8'h42;
        @(negedge clk);
        in_data  = 8'h43;
        @(negedge clk);
        in_valid = 1'b0;
        waitIdle(200, "t2");
        check("t2_count", 32'(gotQ.size()), 32'd3);
        if (gotQ.size() >= 3) begin
            check("t2_byte0", 32'(gotQ[0]), 32'h41);
            check("t2_byte1", 32'(gotQ[1]), 32'h42);
            check("t2_byte2", 32'(gotQ[2]), 32'h43);
        end
        check("t2_byte_cnt", 32'(dut.byteCnt), 32'd3);
        check("t2_block_count", 32'(block_count), 32'd0);

        // T3: flush closes the partial block; a second flush sends nothing
        pulseFlush();
        waitIdle(200, "t3");
        check("t3_count", 32'(gotQ.size()), 32'd4);
        if (gotQ.size() >= 4) begin
            check("t3_token", 32'(gotQ[3]), 32'h2D);
        end
        check("t3_block_count", 32'(block_count), 32'd1);
        check("t3_byte_cnt", 32'(dut.byteCnt), 32'd0);
        pulseFlush();
        repeat (10) @(negedge clk);
        check("t3_no_empty_block", 32'(gotQ.size()), 32'd4);
        check("t3_block_count2", 32'(block_count), 32'd1);
        check("t3_flush_cleared", 32'(busy), 32'd0);

        // T4: writer held off, 17 pushes into a 16-deep FIFO
        sd_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            in_valid = vecs[i].valid;
            in_data  = vecs[i].data;
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("t4_count_%0d", i), 32'(fifo_count), 32'(vecs[i].expCount));
            check($sformatf("t4_ready_%0d", i), 32'(in_ready), 32'(vecs[i].expReady));
            check($sformatf("t4_ovf_%0d", i), 32'(overflow), 32'(vecs[i].expOvf));
        end
        check("t4_no_start", 32'(fo_start), 32'd0);
        check("t4_busy", 32'(busy), 32'd1);
        sd_ready = 1'b1;
        waitIdle(400, "t4");
        check("t4_drained", 32'(gotQ.size()), 32'd20);
        for (int i = 0; i < 16; i++) begin
            if (4 + i < gotQ.size()) begin
                check($sformatf("t4_byte_%0d", i), 32'(gotQ[4 + i]), 32'h60 + 32'(i));
            end
        end
        check("t4_overflow_sticky", 32'(overflow), 32'd1);
        check("t4_byte_cnt", 32'(dut.byteCnt), 32'd16);

        // T5: full block of zeros closes on the 512th byte
        pulseFlush();
        waitIdle(200, "t5_flush");
        check("t5_block_after_flush", 32'(block_count), 32'd2);
        check("t5_byte_cnt_after_flush", 32'(dut.byteCnt), 32'd0);
        base = gotQ.size();
        feed(511, 8'h00);
        waitIdle(4000, "t5_511");
        check("t5_delivered_511", 32'(gotQ.size() - base), 32'd511);
        check("t5_byte_cnt_511", 32'(dut.byteCnt), 32'd511);
        check("t5_block_511", 32'(block_count), 32'd2);
        feed(1, 8'h00);
        waitIdle(100, "t5_512");
        check("t5_byte_cnt_512", 32'(dut.byteCnt), 32'd0);
        check("t5_block_512", 32'(block_count), 32'd3);
        feed(1, 8'h00);
        waitIdle(100, "t5_513");
        check("t5_byte_cnt_513", 32'(dut.byteCnt), 32'd1);
        check("t5_block_513", 32'(block_count), 32'd3);

        // T6: reset while in ACK
        writerEn     = 1'b0;
        manualFinish = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(negedge clk);
        in_data  = 8'h66;
        @(negedge clk);
        in_valid = 1'b0;
        check("t6_req", 32'(fo_start), 32'd1);
        check("t6_req_data", 32'(fo_data), 32'h55);
        manualFinish = 1'b0;
        @(negedge clk);
        check("t6_ack_start", 32'(fo_start), 32'd1);
        check("t6_ack_fifo", 32'(fifo_count), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_start", 32'(fo_start), 32'd0);
        check("t6_async_fifo", 32'(fifo_count), 32'd0);
        @(negedge clk);
        reset        = 1'b1;
        manualFinish = 1'b1;
        sd_ready     = 1'b0;
        @(negedge clk);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_fifo", 32'(fifo_count), 32'd0);
        check("t6_start", 32'(fo_start), 32'd0);
        check("t6_overflow", 32'(overflow), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        check("t6_block_count", 32'(block_count), 32'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
